ld_st_queue: RTL and testbench
==============================

LD_ST_QUEUE -- requirements
Module: ld_st_queue

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries (power of two).
REQ-002 clk  in  1  rising-edge clock, single clock domain.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 alloc_valid  in  1  dispatch requests a new entry this cycle.
REQ-005 alloc_ld_st  in  1  1 = store, 0 = load.
REQ-006 alloc_funct3  in  4  access size code: 0 = byte, 1 = half, 2 = word.
REQ-007 alloc_dest_rob  in  8  ROB tag of the ld/st instruction.
REQ-008 alloc_data_rob, alloc_data_valid, alloc_data  in  8/1/32  store source tag, valid flag, value.
REQ-009 full  out  1  count == DEPTH.
REQ-010 agu_valid, agu_rob, agu_addr  in  1/8/32  computed effective address tagged with the owning dest_rob.
REQ-011 cdb_valid, cdb_rob, cdb_value  in  1/8/32  result broadcast bus.
REQ-012 commit  in  1  single-cycle pulse from mem_controller; dequeues the head entry.
REQ-013 flush  in  1  synchronous clear of all entries.
REQ-014 cir_q_empty  out  1  count == 0.
REQ-015 Head outputs, all out: ld_st_data_at_commit 1, mem_address_data_at_commit 32, src_rob_mem_address_data_at_commit 8, valid_mem_address_data_at_commit 1, write_data_at_commit 32, src_rob_data_at_commit 8, src_valid_data_at_commit 1, dest_rob_data_at_commit 8, funct3_data_at_commit 4.
REQ-016 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Structure: circular FIFO with head/tail pointers of $clog2(DEPTH) bits; both pointers wrap from DEPTH-1 to 0.
REQ-018 Allocate: when alloc_valid && !full, write the entry at tail, set the entry's valid bit, set addr_valid = 0, increment tail.
REQ-019 When full, alloc_valid is ignored, even if commit is asserted in the same cycle; no state changes.
REQ-020 Allocation bypass: if alloc_data_valid = 0 and, in the same cycle, cdb_valid && cdb_rob == alloc_data_rob, store cdb_value with data valid = 1.
REQ-021 Address capture: on agu_valid, every valid entry with dest_rob == agu_rob and addr_valid = 0 latches agu_addr and sets addr_valid = 1.
REQ-022 Address capture also applies to an entry being allocated in the same cycle.
REQ-023 Data capture: on cdb_valid, every valid store entry with data valid = 0 and data_rob == cdb_rob latches cdb_value and sets data valid = 1.
REQ-024 Captured address and data become visible on the head outputs the cycle after the capture.
REQ-025 An allocated entry is visible at the head one cycle after allocation when the queue was empty.
REQ-026 Head outputs are combinational from the head entry.
REQ-027 src_rob_mem_address_data_at_commit = head dest_rob.
REQ-028 When the queue is empty, all head outputs are 0.
REQ-029 Dequeue: commit && !cir_q_empty clears the head entry's valid bit and increments head.
REQ-030 commit while the queue is empty is ignored.
REQ-031 Simultaneous allocate and dequeue, not full and not empty: both take effect and count is unchanged.
REQ-032 Simultaneous allocate and dequeue when empty: the allocate takes effect and the commit is ignored.
REQ-033 A CDB or AGU update that targets the head entry in the same cycle as its dequeue is dropped.
REQ-034 Priority: flush > commit/alloc; flush clears all valid bits, head, tail and count next cycle.
REQ-035 funct3 is stored unmodified; the queue performs no alignment checks.

Reset
REQ-036 While rst = 0, asynchronously clear head, tail, count and every entry valid, addr_valid and data valid bit.
REQ-037 During reset: cir_q_empty = 1, full = 0, all head outputs = 0.
REQ-038 Reset mid-operation discards all entries; the first allocation after rst rises lands in entry 0.
REQ-039 Entry payload (address, data, tags) is not required to be reset.

Structure
REQ-040 Package Ld_St_structs holds the lsq_entry_t struct (valid, ld_st, funct3, dest_rob, addr_valid, addr, data_rob, data_valid, data) and LSQ_DEPTH = 8.
REQ-041 Single module, no sub-module; tag comparators are generated per entry.

Verification
REQ-042 Alloc a load (dest_rob 5); AGU (5, 0x100) next cycle -> head valid_mem_address = 1, address 0x100, cir_q_empty = 0; commit -> cir_q_empty = 1.
REQ-043 Alloc a store (data_rob 9, data_valid 0) with CDB (9, 0xDEAD) in the same cycle -> next cycle src_valid = 1, write_data = 0xDEAD.
REQ-044 Alloc 8 entries -> full = 1; 9th alloc with commit -> entry dropped, count = 7; wrap: 4 commits, 4 allocs -> tail at 4, order preserved.
REQ-045 CDB (3, 0x55) with entries 1 and 2 both waiting on tag 3 -> both capture 0x55; an unrelated entry is unchanged.
REQ-046 Flush with count = 5 while alloc and commit are asserted -> next cycle count = 0, cir_q_empty = 1.
REQ-047 Assert rst = 0 asynchronously mid-burst -> outputs clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ld_st_queue_pkg.sv
// Shared types for the load/store queue: the per-entry record and the default depth.
package Ld_St_structs;
  localparam int LSQ_DEPTH = 8;

  typedef struct packed {
    logic        valid;
    logic        ld_st;
    logic [3:0]  funct3;
    logic [7:0]  dest_rob;
    logic        addr_valid;
    logic [31:0] addr;
    logic [7:0]  data_rob;
    logic        data_valid;
    logic [31:0] data;
  } lsq_entry_t;
endpackage

// File: rtl/ld_st_queue.sv
// In-order load/store queue: circular FIFO of memory ops that gathers effective
// addresses from the AGU and store data from the CDB until the head commits.
module ld_st_queue
  import Ld_St_structs::*;
#(
  parameter int DEPTH = LSQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  input  logic                     alloc_ld_st,
  input  logic [3:0]               alloc_funct3,
  input  logic [7:0]               alloc_dest_rob,
  input  logic [7:0]               alloc_data_rob,
  input  logic                     alloc_data_valid,
  input  logic [31:0]              alloc_data,
  output logic                     full,
  input  logic                     agu_valid,
  input  logic [7:0]               agu_rob,
  input  logic [31:0]              agu_addr,
  input  logic                     cdb_valid,
  input  logic [7:0]               cdb_rob,
  input  logic [31:0]              cdb_value,
  input  logic                     commit,
  input  logic                     flush,
  output logic                     cir_q_empty,
  output logic                     ld_st_data_at_commit,
  output logic [31:0]              mem_address_data_at_commit,
  output logic [7:0]               src_rob_mem_address_data_at_commit,
  output logic                     valid_mem_address_data_at_commit,
  output logic [31:0]              write_data_at_commit,
  output logic [7:0]               src_rob_data_at_commit,
  output logic                     src_valid_data_at_commit,
  output logic [7:0]               dest_rob_data_at_commit,
  output logic [3:0]               funct3_data_at_commit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lsq_entry_t       entries [DEPTH];
  lsq_entry_t       new_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_alloc;
  logic             do_deq;
  logic [DEPTH-1:0] addr_hit;
  logic [DEPTH-1:0] data_hit;

  assign full        = (count == CNT_W'(DEPTH));
  assign cir_q_empty = (count == '0);
  assign do_alloc    = alloc_valid && !full && !flush;
  assign do_deq      = commit && !cir_q_empty && !flush;

  // The entry being written at tail also sees this cycle's AGU and CDB traffic.
  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.ld_st      = alloc_ld_st;
    new_entry.funct3     = alloc_funct3;
    new_entry.dest_rob   = alloc_dest_rob;
    new_entry.data_rob   = alloc_data_rob;
    new_entry.addr_valid = agu_valid && (agu_rob == alloc_dest_rob);
    new_entry.addr       = agu_addr;
    new_entry.data_valid = alloc_data_valid;
    new_entry.data       = alloc_data;
    if (!alloc_data_valid && cdb_valid && (cdb_rob == alloc_data_rob)) begin
      new_entry.data_valid = 1'b1;
      new_entry.data       = cdb_value;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic leaving;
    assign leaving     = do_deq && (head == PTR_W'(i));
    assign addr_hit[i] = agu_valid && entries[i].valid && !entries[i].addr_valid &&
                         (entries[i].dest_rob == agu_rob) && !leaving;
    assign data_hit[i] = cdb_valid && entries[i].valid && entries[i].ld_st &&
                         !entries[i].data_valid && (entries[i].data_rob == cdb_rob) && !leaving;
  end

  // Only the status bits and pointers are reset; payload is qualified by them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid      <= 1'b0;
        entries[i].addr_valid <= 1'b0;
        entries[i].data_valid <= 1'b0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid      <= 1'b0;
        entries[i].addr_valid <= 1'b0;
        entries[i].data_valid <= 1'b0;
      end
    end else begin
      if (do_alloc) begin
        entries[tail] <= new_entry;
        tail          <= tail + 1'b1;
      end
      if (do_deq) begin
        entries[head].valid <= 1'b0;
        head                <= head + 1'b1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_hit[i]) begin
          entries[i].addr_valid <= 1'b1;
          entries[i].addr       <= agu_addr;
        end
        if (data_hit[i]) begin
          entries[i].data_valid <= 1'b1;
          entries[i].data       <= cdb_value;
        end
      end
      unique case ({do_alloc, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign ld_st_data_at_commit               = !cir_q_empty && entries[head].ld_st;
  assign mem_address_data_at_commit         = cir_q_empty ? '0 : entries[head].addr;
  assign src_rob_mem_address_data_at_commit = cir_q_empty ? '0 : entries[head].dest_rob;
  assign valid_mem_address_data_at_commit   = !cir_q_empty && entries[head].addr_valid;
  assign write_data_at_commit               = cir_q_empty ? '0 : entries[head].data;
  assign src_rob_data_at_commit             = cir_q_empty ? '0 : entries[head].data_rob;
  assign src_valid_data_at_commit           = !cir_q_empty && entries[head].data_valid;
  assign dest_rob_data_at_commit            = cir_q_empty ? '0 : entries[head].dest_rob;
  assign funct3_data_at_commit              = cir_q_empty ? '0 : entries[head].funct3;

endmodule

// File: tb/tb_ld_st_queue.sv
// Directed bench for ld_st_queue: a table of single-cycle vectors plus
// hand-written full/wrap, flush and asynchronous-reset sequences.
module tb_ld_st_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_valid, alloc_ld_st, alloc_data_valid;
  logic [3:0]  alloc_funct3;
  logic [7:0]  alloc_dest_rob, alloc_data_rob;
  logic [31:0] alloc_data;
  logic        full, cir_q_empty;
  logic        agu_valid, cdb_valid, commit, flush;
  logic [7:0]  agu_rob, cdb_rob;
  logic [31:0] agu_addr, cdb_value;
  logic        ld_st_data_at_commit, valid_mem_address_data_at_commit, src_valid_data_at_commit;
  logic [31:0] mem_address_data_at_commit, write_data_at_commit;
  logic [7:0]  src_rob_mem_address_data_at_commit, src_rob_data_at_commit, dest_rob_data_at_commit;
  logic [3:0]  funct3_data_at_commit;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  ld_st_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ld_st(alloc_ld_st), .alloc_funct3(alloc_funct3),
    .alloc_dest_rob(alloc_dest_rob), .alloc_data_rob(alloc_data_rob),
    .alloc_data_valid(alloc_data_valid), .alloc_data(alloc_data), .full(full),
    .agu_valid(agu_valid), .agu_rob(agu_rob), .agu_addr(agu_addr),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .commit(commit), .flush(flush), .cir_q_empty(cir_q_empty),
    .ld_st_data_at_commit(ld_st_data_at_commit),
    .mem_address_data_at_commit(mem_address_data_at_commit),
    .src_rob_mem_address_data_at_commit(src_rob_mem_address_data_at_commit),
    .valid_mem_address_data_at_commit(valid_mem_address_data_at_commit),
    .write_data_at_commit(write_data_at_commit),
    .src_rob_data_at_commit(src_rob_data_at_commit),
    .src_valid_data_at_commit(src_valid_data_at_commit),
    .dest_rob_data_at_commit(dest_rob_data_at_commit),
    .funct3_data_at_commit(funct3_data_at_commit),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        av, ls;
    logic [7:0]  drob, dtag;
    logic        dv;
    logic [31:0] dat;
    logic        agv;
    logic [7:0]  agr;
    logic [31:0] aga;
    logic        cv;
    logic [7:0]  cr;
    logic [31:0] cval;
    logic        cm;
    logic [3:0]  ec;
    logic [7:0]  ed;
    logic        els, eav;
    logic [31:0] ea;
    logic        esv;
    logic [31:0] ew;
  } vec_t;

  function automatic vec_t mk(string nm, logic av, logic ls, logic [7:0] drob, logic [7:0] dtag,
                              logic dv, logic [31:0] dat, logic agv, logic [7:0] agr,
                              logic [31:0] aga, logic cv, logic [7:0] cr, logic [31:0] cval,
                              logic cm, logic [3:0] ec, logic [7:0] ed, logic els, logic eav,
                              logic [31:0] ea, logic esv, logic [31:0] ew);
    vec_t v;
    v.nm = nm; v.av = av; v.ls = ls; v.drob = drob; v.dtag = dtag; v.dv = dv; v.dat = dat;
    v.agv = agv; v.agr = agr; v.aga = aga; v.cv = cv; v.cr = cr; v.cval = cval; v.cm = cm;
    v.ec = ec; v.ed = ed; v.els = els; v.eav = eav; v.ea = ea; v.esv = esv; v.ew = ew;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_ld_st = 0; alloc_funct3 = 0; alloc_dest_rob = 0;
    alloc_data_rob = 0; alloc_data_valid = 0; alloc_data = 0;
    agu_valid = 0; agu_rob = 0; agu_addr = 0;
    cdb_valid = 0; cdb_rob = 0; cdb_value = 0; commit = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic alloc(input logic ls, input logic [3:0] f3, input logic [7:0] drob,
                       input logic dv, input logic [31:0] dat);
    alloc_valid = 1; alloc_ld_st = ls; alloc_funct3 = f3; alloc_dest_rob = drob;
    alloc_data_rob = 8'hF0; alloc_data_valid = dv; alloc_data = dat;
    step();
  endtask

  task automatic do_commit();
    commit = 1;
    step();
  endtask

  task automatic chk_empty_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(cir_q_empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_dest"}, 32'(dest_rob_data_at_commit), 32'd0);
    chk({tag, "_addr_v"}, 32'(valid_mem_address_data_at_commit), 32'd0);
    chk({tag, "_src_v"}, 32'(src_valid_data_at_commit), 32'd0);
  endtask

  vec_t vecs [$];
  logic [7:0] order [7];

  initial begin
    idle();
    #3;
    chk_empty_outputs("reset");
    @(negedge clk);
    rst = 1;

    //          name         av ls drob dtag dv dat       agv agr aga      cv cr cval     cm  ec ed  els eav ea       esv ew
    vecs.push_back(mk("ld_alloc",  1,0, 5, 0, 0,0,         0,0,0,          0,0,0,          0,  1, 5, 0,0,0,          0,0));
    vecs.push_back(mk("agu_cap",   0,0, 0, 0, 0,0,         1,5,32'h100,    0,0,0,          0,  1, 5, 0,1,32'h100,    0,0));
    vecs.push_back(mk("commit_ld", 0,0, 0, 0, 0,0,         0,0,0,          0,0,0,          1,  0, 0, 0,0,0,          0,0));
    vecs.push_back(mk("st_bypass", 1,1, 7, 9, 0,0,         0,0,0,          1,9,32'hDEAD,   0,  1, 7, 1,0,0,          1,32'hDEAD));
    vecs.push_back(mk("st_agu",    0,0, 0, 0, 0,0,         1,7,32'h200,    1,9,32'hBEEF,   0,  1, 7, 1,1,32'h200,    1,32'hDEAD));
    vecs.push_back(mk("commit_st", 0,0, 0, 0, 0,0,         0,0,0,          0,0,0,          1,  0, 0, 0,0,0,          0,0));
    vecs.push_back(mk("alloc_a",   1,1,10, 3, 1,32'hA5A5,  0,0,0,          0,0,0,          0,  1,10, 1,0,0,          1,32'hA5A5));
    vecs.push_back(mk("alloc_b",   1,1,11, 3, 0,0,         0,0,0,          0,0,0,          0,  2,10, 1,0,0,          1,32'hA5A5));
    vecs.push_back(mk("alloc_c",   1,1,12, 3, 0,0,         0,0,0,          0,0,0,          0,  3,10, 1,0,0,          1,32'hA5A5));
    vecs.push_back(mk("cdb_multi", 0,0, 0, 0, 0,0,         0,0,0,          1,3,32'h55,     0,  3,10, 1,0,0,          1,32'hA5A5));
    vecs.push_back(mk("head_b",    0,0, 0, 0, 0,0,         0,0,0,          0,0,0,          1,  2,11, 1,0,0,          1,32'h55));
    vecs.push_back(mk("head_c",    0,0, 0, 0, 0,0,         0,0,0,          0,0,0,          1,  1,12, 1,0,0,          1,32'h55));
    vecs.push_back(mk("cdb_late",  0,0, 0, 0, 0,0,         0,0,0,          1,3,32'h77,     0,  1,12, 1,0,0,          1,32'h55));
    vecs.push_back(mk("drain",     0,0, 0, 0, 0,0,         0,0,0,          0,0,0,          1,  0, 0, 0,0,0,          0,0));
    vecs.push_back(mk("cm_empty",  0,0, 0, 0, 0,0,         0,0,0,          0,0,0,          1,  0, 0, 0,0,0,          0,0));
    vecs.push_back(mk("al_cm_emp", 1,0,20, 0, 0,0,         1,20,32'h300,   0,0,0,          1,  1,20, 0,1,32'h300,    0,0));
    vecs.push_back(mk("drain2",    0,0, 0, 0, 0,0,         0,0,0,          0,0,0,          1,  0, 0, 0,0,0,          0,0));

    foreach (vecs[k]) begin
      alloc_valid = vecs[k].av; alloc_ld_st = vecs[k].ls; alloc_funct3 = 4'd2;
      alloc_dest_rob = vecs[k].drob; alloc_data_rob = vecs[k].dtag;
      alloc_data_valid = vecs[k].dv; alloc_data = vecs[k].dat;
      agu_valid = vecs[k].agv; agu_rob = vecs[k].agr; agu_addr = vecs[k].aga;
      cdb_valid = vecs[k].cv; cdb_rob = vecs[k].cr; cdb_value = vecs[k].cval;
      commit = vecs[k].cm;
      step();
      chk({vecs[k].nm, "_count"}, 32'(count), 32'(vecs[k].ec));
      chk({vecs[k].nm, "_empty"}, 32'(cir_q_empty), 32'(vecs[k].ec == 0));
      chk({vecs[k].nm, "_full"}, 32'(full), 32'(vecs[k].ec == 8));
      chk({vecs[k].nm, "_dest"}, 32'(dest_rob_data_at_commit), 32'(vecs[k].ed));
      chk({vecs[k].nm, "_srcrob_ma"}, 32'(src_rob_mem_address_data_at_commit), 32'(vecs[k].ed));
      chk({vecs[k].nm, "_ld_st"}, 32'(ld_st_data_at_commit), 32'(vecs[k].els));
      chk({vecs[k].nm, "_addr_v"}, 32'(valid_mem_address_data_at_commit), 32'(vecs[k].eav));
      chk({vecs[k].nm, "_src_v"}, 32'(src_valid_data_at_commit), 32'(vecs[k].esv));
      if (vecs[k].eav || vecs[k].ec == 0)
        chk({vecs[k].nm, "_addr"}, mem_address_data_at_commit, vecs[k].ea);
      if (vecs[k].esv || vecs[k].ec == 0)
        chk({vecs[k].nm, "_wdata"}, write_data_at_commit, vecs[k].ew);
    end

    // Full queue, dropped alloc under commit, then wrap-around ordering.
    rst = 0;
    #2;
    rst = 1;
    for (int i = 0; i < 8; i++) alloc(1'b0, 4'd0, 8'(30 + i), 1'b0, 32'd0);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_head", 32'(dest_rob_data_at_commit), 32'd30);
    alloc_valid = 1; alloc_dest_rob = 8'd99; commit = 1;
    step();
    chk("drop_count", 32'(count), 32'd7);
    chk("drop_full", 32'(full), 32'd0);
    chk("drop_head", 32'(dest_rob_data_at_commit), 32'd31);
    for (int i = 0; i < 4; i++) do_commit();
    chk("wrap_pop_count", 32'(count), 32'd3);
    for (int i = 0; i < 4; i++) alloc(1'b0, 4'd0, 8'(40 + i), 1'b0, 32'd0);
    chk("wrap_push_count", 32'(count), 32'd7);
    order = '{8'd35, 8'd36, 8'd37, 8'd40, 8'd41, 8'd42, 8'd43};
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("wrap_order_%0d", i), 32'(dest_rob_data_at_commit), 32'(order[i]));
      do_commit();
    end
    chk("wrap_empty", 32'(cir_q_empty), 32'd1);

    // Flush beats simultaneous alloc and commit.
    for (int i = 0; i < 5; i++) alloc(1'b1, 4'd1, 8'(60 + i), 1'b1, 32'(i));
    chk("pre_flush_count", 32'(count), 32'd5);
    flush = 1; commit = 1; alloc_valid = 1; alloc_dest_rob = 8'd70;
    step();
    chk_empty_outputs("flush");
    alloc(1'b1, 4'hA, 8'd71, 1'b1, 32'hCAFE);
    chk("post_flush_count", 32'(count), 32'd1);
    chk("post_flush_dest", 32'(dest_rob_data_at_commit), 32'd71);
    chk("post_flush_f3", 32'(funct3_data_at_commit), 32'hA);
    chk("post_flush_ldst", 32'(ld_st_data_at_commit), 32'd1);
    chk("post_flush_wdata", write_data_at_commit, 32'hCAFE);
    chk("post_flush_srcrob", 32'(src_rob_data_at_commit), 32'hF0);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) alloc(1'b0, 4'd2, 8'(80 + i), 1'b0, 32'd0);
    chk("pre_rst_count", 32'(count), 32'd4);
    #2;
    rst = 0;
    #1;
    chk_empty_outputs("async_rst");
    @(negedge clk);
    rst = 1;
    alloc(1'b0, 4'd2, 8'd90, 1'b0, 32'd0);
    chk("post_rst_count", 32'(count), 32'd1);
    chk("post_rst_dest", 32'(dest_rob_data_at_commit), 32'd90);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
